// File: rtl/mipi_csi2_pkg.sv
// Shared definitions for the CSI-2 packet parser.
// Holds the CSI-2 data-type codes, the parser state encoding, the header ECC
// syndrome calculation and the byte-enable helper for the final payload word.
package mipi_csi2_pkg;

  // CSI-2 data-type field values (6-bit DT portion of the DI byte).
  typedef enum logic [5:0] {
    DT_FS    = 6'h00,
    DT_FE    = 6'h01,
    DT_LS    = 6'h02,
    DT_LE    = 6'h03,
    DT_RAW8  = 6'h2A,
    DT_RAW10 = 6'h2B
  } data_type_t;

  // Data types 0x00-0x0F are short packets: header only, no payload or CRC.
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  // Hamming syndrome of a packet header. Each mask selects the header bits
  // covered by one parity bit; a zero result means the header is intact.
  function automatic logic [5:0] ecc_syndrome(input logic [23:0] hdr,
                                              input logic [5:0]  ecc);
    logic [5:0] parity;
    parity[0] = ^(hdr & 24'hF12CB7);
    parity[1] = ^(hdr & 24'hF2555B);
    parity[2] = ^(hdr & 24'h749A6D);
    parity[3] = ^(hdr & 24'hB8E38E);
    parity[4] = ^(hdr & 24'hDF03F0);
    parity[5] = ^(hdr & 24'hEFFC00);
    return parity ^ ecc;
  endfunction

  // Byte enables for a final word holding n (1..4) payload bytes.
  function automatic logic [3:0] tail_keep(input logic [2:0] n);
    case (n)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mipi_csi2_crc16.sv
// CSI-2 payload CRC-16 (x^16+x^12+x^5+1, reflected, LSB-first) folding up to
// four bytes per cycle into a running value.
// Ports:
//   init    - start from the seed instead of crc_in
//   crc_in  - running CRC carried from the previous word
//   data    - four bytes, byte0 = [7:0] processed first
//   keep    - byte enables, contiguous from bit0
//   crc_out - updated CRC (equals the start value when keep is zero)
module mipi_csi2_crc16
  import mipi_csi2_pkg::*;
(
  input  logic        init,
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  keep,
  output logic [15:0] crc_out
);

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in,
                                           input logic [7:0]  d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_comb begin
    crc_out = init ? CRC_SEED : crc_in;
    for (int b = 0; b < 4; b++) begin
      if (keep[b]) crc_out = crc_byte(crc_out, data[8*b +: 8]);
    end
  end

endmodule

// File: rtl/mipi_csi2_pkt_parser.sv
// CSI-2 packet parser for a lane-merged 32-bit byte stream.
// Validates header ECC, decodes frame start/end short packets, forwards the
// payload of long packets matching DT_SEL/VC_SEL one cycle after input, and
// checks the trailing CRC-16.
// Ports:
//   ACLK, ARESETN          - clock, async active-low reset
//   in_data/in_valid/in_sop - input words; in_sop marks a packet header word
//   out_data/out_keep       - payload word and byte enables
//   out_valid/out_last/out_sof - payload qualifiers
//   frame_start/frame_end   - FS/FE pulses for VC_SEL
//   ecc_err/crc_err/trunc_err - single-cycle error pulses
//   frame_cnt               - number of FS packets seen on VC_SEL
module mipi_csi2_pkt_parser
  import mipi_csi2_pkg::*;
#(
  parameter logic [7:0] DT_SEL = 8'h2B,
  parameter logic [1:0] VC_SEL = 2'd0
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_valid,
  output logic        out_last,
  output logic        out_sof,
  output logic        frame_start,
  output logic        frame_end,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        trunc_err,
  output logic [15:0] frame_cnt
);

  state_t      state;
  logic [15:0] rem;
  logic        crc_half;
  logic [7:0]  crc_lo;
  logic        crc_first;
  logic [15:0] crc_reg;
  logic        sof_armed;

  logic        is_hdr;
  logic        is_word;
  logic        hdr_ok;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic        last_word;
  logic [3:0]  word_keep;
  logic [3:0]  crc_keep;
  logic [15:0] crc_calc;
  logic [15:0] rx_inline;
  logic [15:0] rx_tail;

  assign is_hdr  = in_valid & in_sop;
  assign is_word = in_valid & ~in_sop;
  assign hdr_dt  = in_data[5:0];
  assign hdr_vc  = in_data[7:6];
  assign hdr_wc  = in_data[23:8];

  // The two top ECC bits are reserved and must be zero in a valid header.
  assign hdr_ok = (ecc_syndrome(in_data[23:0], in_data[29:24]) == 6'd0) &&
                  (in_data[31:30] == 2'b00);

  assign last_word = (rem <= 16'd4);
  assign word_keep = last_word ? tail_keep(rem[2:0]) : 4'hF;

  // Outside PAYLOAD no bytes are folded, so crc_calc is the finished CRC
  // (or the seed for a zero-length packet) ready for comparison.
  assign crc_keep = (state == ST_PAYLOAD) ? word_keep : 4'h0;

  mipi_csi2_crc16 u_crc (
    .init    (crc_first),
    .crc_in  (crc_reg),
    .data    (in_data),
    .keep    (crc_keep),
    .crc_out (crc_calc)
  );

  // With 1 or 2 payload bytes in the final word, both CRC bytes follow in the
  // same word; with 3 or 4, the CRC spills into the next word.
  assign rx_inline = rem[0] ? in_data[23:8] : in_data[31:16];
  assign rx_tail   = crc_half ? {in_data[7:0], crc_lo} : in_data[15:0];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= ST_IDLE;
      rem         <= 16'd0;
      crc_half    <= 1'b0;
      crc_lo      <= 8'd0;
      crc_first   <= 1'b0;
      crc_reg     <= 16'd0;
      sof_armed   <= 1'b0;
      out_data    <= 32'd0;
      out_keep    <= 4'd0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_sof     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      ecc_err     <= 1'b0;
      crc_err     <= 1'b0;
      trunc_err   <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      out_data    <= 32'd0;
      out_keep    <= 4'd0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_sof     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      ecc_err     <= 1'b0;
      crc_err     <= 1'b0;
      trunc_err   <= 1'b0;

      if (is_hdr) begin
        // A header always wins: an unfinished packet is abandoned and the
        // new header is decoded in the same cycle.
        trunc_err <= (state == ST_PAYLOAD) || (state == ST_CRC);
        if (!hdr_ok) begin
          ecc_err <= 1'b1;
          state   <= ST_DROP;
        end else if (hdr_dt <= DT_SHORT_MAX) begin
          state <= ST_IDLE;
          if (hdr_vc == VC_SEL) begin
            case (hdr_dt)
              DT_FS: begin
                frame_start <= 1'b1;
                frame_cnt   <= frame_cnt + 16'd1;
                sof_armed   <= 1'b1;
              end
              DT_FE:   frame_end <= 1'b1;
              default: ;
            endcase
          end
        end else if ((hdr_dt == DT_SEL[5:0]) && (hdr_vc == VC_SEL)) begin
          rem       <= hdr_wc;
          crc_first <= 1'b1;
          crc_half  <= 1'b0;
          state     <= (hdr_wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
        end else begin
          state <= ST_DROP;
        end
      end else if (is_word) begin
        case (state)
          ST_PAYLOAD: begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= word_keep;
            out_sof   <= sof_armed;
            sof_armed <= 1'b0;
            crc_reg   <= crc_calc;
            crc_first <= 1'b0;
            if (!last_word) begin
              rem <= rem - 16'd4;
            end else begin
              out_last <= 1'b1;
              rem      <= 16'd0;
              case (rem[2:0])
                3'd4: begin
                  crc_half <= 1'b0;
                  state    <= ST_CRC;
                end
                3'd3: begin
                  crc_half <= 1'b1;
                  crc_lo   <= in_data[31:24];
                  state    <= ST_CRC;
                end
                default: begin
                  crc_err <= (rx_inline != crc_calc);
                  state   <= ST_IDLE;
                end
              endcase
            end
          end
          ST_CRC: begin
            crc_err <= (rx_tail != crc_calc);
            state   <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/mipi_csi2_pkt_parser.md
MIPI_CSI2_PKT_PARSER -- requirements
Module: mipi_csi2_pkt_parser

Interface
REQ-001 SHALL have parameter DT_SEL, default 8'h2B (RAW10), data type of long packets forwarded.
REQ-002 SHALL have parameter VC_SEL, default 2'd0, virtual channel of packets forwarded and framed.
REQ-003 ACLK  in  1  sole clock; all logic rising-edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 in_data  in  32  lane-merged bytes, byte0 = [7:0] = first on wire.
REQ-006 in_valid  in  1  in_data valid this cycle; no backpressure possible.
REQ-007 in_sop  in  1  qualified by in_valid; word is a packet header {ECC,WC_hi,WC_lo,DI}.
REQ-008 out_data  out  32  payload bytes.
REQ-009 out_keep  out  4  byte enables, contiguous from bit0.
REQ-010 out_valid  out  1  payload word valid.
REQ-011 out_last  out  1  last payload word of a line.
REQ-012 out_sof  out  1  first payload word after frame start.
REQ-013 frame_start, frame_end  out  1 each  one-cycle pulses on FS/FE short packets of VC_SEL.
REQ-014 ecc_err, crc_err, trunc_err  out  1 each  one-cycle error pulses.
REQ-015 frame_cnt  out  16  count of FS packets on VC_SEL, wraps 0xFFFF->0.

Function
REQ-016 SHALL implement states IDLE, PAYLOAD, CRC, DROP; header accepted only when in_valid & in_sop.
REQ-017 Header ECC: 6-bit CSI-2 Hamming syndrome over bytes 0-2; nonzero syndrome -> ecc_err pulse next cycle, packet discarded (no correction), state DROP until next in_sop.
REQ-018 Short packets (DT 0x00-0x0F): FS -> frame_start, frame_cnt+1, arm out_sof; FE -> frame_end; others ignored; state stays IDLE; no payload expected.
REQ-019 Long packet with DT==DT_SEL and VC==VC_SEL -> PAYLOAD, byte counter loaded with WC; any other long packet -> DROP.
REQ-020 In PAYLOAD each in_valid word SHALL appear on out_* exactly 1 cycle later; out_keep = 4'hF except final word, where keep covers remaining bytes (WC mod 4, 0 meaning 4).
REQ-021 out_last SHALL coincide with the word carrying byte WC-1; out_sof on first payload word after an FS, cleared once used.
REQ-022 in_valid low cycles SHALL stall the parser without state change; outputs idle (out_valid=0).
REQ-023 CRC: CSI-2 CRC-16 (poly x^16+x^12+x^5+1, seed 0xFFFF, LSB-first) over payload bytes; received CRC located at byte offset WC in the packet, may straddle the last payload word and the next word.
REQ-024 crc_err SHALL pulse no later than 2 cycles after the cycle carrying the final CRC byte on mismatch; state returns IDLE.
REQ-025 WC==0 long packet: no out_valid, go to CRC state, CRC checked against seed.
REQ-026 in_sop while in PAYLOAD or CRC: trunc_err pulse, no out_last emitted for aborted line, new header processed in that same cycle.
REQ-027 Bytes after CRC until next in_sop SHALL be ignored (lane padding).

Reset
REQ-028 ARESETN low SHALL immediately force state IDLE, all outputs 0, frame_cnt 0, out_sof disarmed.
REQ-029 Reset mid-packet SHALL discard the packet; first post-reset action requires a new in_sop.

Structure
REQ-030 Package mipi_csi2_pkg SHALL hold data-type constants (FS/FE/LS/LE/RAW8/RAW10), state enum, ECC syndrome function.
REQ-031 Sub-module mipi_csi2_crc16 SHALL compute CRC over 1-4 bytes/cycle with byte enables, init and running-value ports.

Verification
REQ-032 FS, long DT 0x2B WC=0x000A correct CRC, FE -> frame_start, 3 out words keep F,F,3, out_sof on word0, out_last on word2, frame_end, frame_cnt=1, no errors.
REQ-033 Same long packet with one header bit flipped -> ecc_err pulse, no out_valid for that packet.
REQ-034 WC=0x0008 with CRC byte corrupted -> 2 full words output, crc_err pulse within 2 cycles of CRC word.
REQ-035 WC=0x0007 (CRC straddles words), in_valid gapped every other cycle -> output words track input +1 cycle, keep F,7, correct CRC, no errors.
REQ-036 in_sop asserted mid-payload of WC=0x0040 -> trunc_err, new packet parsed correctly; DT 0x2A packet -> no output.
REQ-037 ARESETN pulsed low mid-payload -> outputs 0 asynchronously, frame_cnt=0, next full frame parses correctly.
